// File: rtl/pipe_ctrl_pkg.sv
// Purpose: shared types and constants for the pipeline stall/bubble/flush controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Controller state: RUN while the pipe advances, MEM_WAIT while any memory port holds it
  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  // Pipeline register indices for the classic 5-stage pipe
  localparam int STG_IFID  = 0;
  localparam int STG_IDEX  = 1;
  localparam int STG_EXMEM = 2;
  localparam int STG_MEMWB = 3;

  // Default parameter values for pipe_stall_ctrl
  localparam int DEF_NUM_PORTS    = 2;
  localparam int DEF_NUM_STAGES   = STG_MEMWB + 1;
  localparam int DEF_HAZARD_STAGE = STG_IDEX;
  localparam int DEF_FLUSH_STAGE  = STG_EXMEM;
  localparam int DEF_TIMEOUT      = 1024;
  localparam int DEF_CNT_W        = 32;

endpackage

// File: rtl/sat_counter.sv
// Purpose: saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates on the clock edge after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
// Ports: clk, rst (async, active-high), inc, clr, cnt[W-1:0].
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Purpose: per-stage load/bubble/flush control from N memory ports, load-use hazard and branch flush.
// Latency: combinational; a cycle whose outstanding ports all respond releases the pipe in that same cycle.
// Backpressure: holds every stage while any port still waits; flushes seen during a hold are deferred to release.
// Ports: clk, rst (async, active-high); cache_access/mem_resp[NUM_PORTS]; hazard; flush;
//        load/bubble/flush_out[NUM_STAGES]; stall_cycles[CNT_W]; timeout (sticky watchdog).
// TIMEOUT must be at least 2.
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NUM_PORTS    = DEF_NUM_PORTS,
  parameter int NUM_STAGES   = DEF_NUM_STAGES,
  parameter int HAZARD_STAGE = DEF_HAZARD_STAGE,
  parameter int FLUSH_STAGE  = DEF_FLUSH_STAGE,
  parameter int TIMEOUT      = DEF_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_PORTS-1:0]  cache_access,
  input  logic [NUM_PORTS-1:0]  mem_resp,
  input  logic                  hazard,
  input  logic                  flush,
  output logic [NUM_STAGES-1:0] load,
  output logic [NUM_STAGES-1:0] bubble,
  output logic [NUM_STAGES-1:0] flush_out,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  timeout
);

  localparam int WD_W = $clog2(TIMEOUT) + 1;

  state_t               state_q;
  state_t               state_d;
  logic [NUM_PORTS-1:0] done_q;
  logic [NUM_PORTS-1:0] need_v;
  logic [NUM_PORTS-1:0] wait_v;
  logic                 mem_hold;
  logic                 flush_pend_q;
  logic [WD_W-1:0]      wd_cnt;
  logic                 wd_trip;

  // A port that already responded during this hold stops needing service,
  // even though its request stays asserted until the pipe advances.
  assign need_v   = cache_access & ~done_q;
  assign wait_v   = need_v & ~mem_resp;
  assign mem_hold = |wait_v;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_hold)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mem_hold) state_d = RUN;
      default:  state_d = RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    load      = '0;
    bubble    = '0;
    flush_out = '0;
    if (!rst && !mem_hold) begin
      if (flush || flush_pend_q) begin
        // Flush wins over hazard: the instruction causing the hazard is being squashed anyway.
        load = '1;
        for (int s = 0; s < NUM_STAGES; s++) begin
          if (s < FLUSH_STAGE) flush_out[s] = 1'b1;
        end
      end else if (hazard) begin
        // Freeze the stages ahead of the hazard register and inject a NOP into it.
        for (int s = 0; s < NUM_STAGES; s++) begin
          load[s] = (s >= HAZARD_STAGE);
        end
        bubble[HAZARD_STAGE] = 1'b1;
      end else begin
        load = '1;
      end
    end
  end

  // Per-port completion tracking, deferred flush and sticky watchdog flag.
  // Everything tracked for a hold is dropped on the first non-held cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q       <= '0;
      flush_pend_q <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      if (mem_hold) begin
        done_q       <= done_q | (need_v & mem_resp);
        flush_pend_q <= flush_pend_q | flush;
      end else begin
        done_q       <= '0;
        flush_pend_q <= 1'b0;
      end
      if (wd_trip) timeout <= 1'b1;
    end
  end

  // Watchdog: counts MEM_WAIT cycles; timeout rises on the edge where the
  // count reaches TIMEOUT-1 with the hold still in place.
  sat_counter #(.W(WD_W)) u_wd_cnt (
    .clk (clk),
    .rst (rst),
    .inc (state_q == MEM_WAIT),
    .clr (state_q == RUN),
    .cnt (wd_cnt)
  );

  assign wd_trip = (state_q == MEM_WAIT) && mem_hold && (wd_cnt == WD_W'(TIMEOUT - 2));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (mem_hold),
    .clr (1'b0),
    .cnt (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Purpose: directed self-checking bench for pipe_stall_ctrl.
// Latency: inputs driven 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: n/a.
module tb_pipe_stall_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int NP = 2;
  localparam int NS = 4;
  localparam int TO = 16;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [NP-1:0] cache_access;
  logic [NP-1:0] mem_resp;
  logic          hazard;
  logic          flush;
  logic [NS-1:0] load;
  logic [NS-1:0] bubble;
  logic [NS-1:0] flush_out;
  logic [CW-1:0] stall_cycles;
  logic          timeout;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(
    .NUM_PORTS    (NP),
    .NUM_STAGES   (NS),
    .HAZARD_STAGE (1),
    .FLUSH_STAGE  (2),
    .TIMEOUT      (TO),
    .CNT_W        (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cache_access (cache_access),
    .mem_resp     (mem_resp),
    .hazard       (hazard),
    .flush        (flush),
    .load         (load),
    .bubble       (bubble),
    .flush_out    (flush_out),
    .stall_cycles (stall_cycles),
    .timeout      (timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [NP-1:0] acc, input logic [NP-1:0] rsp,
                       input logic hz, input logic fl);
    cache_access = acc;
    mem_resp     = rsp;
    hazard       = hz;
    flush        = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Global bound so a stuck run still ends.
  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // ---- reset state, with requests already asserted ----
    rst = 1'b1;
    drive(2'b11, 2'b00, 1'b0, 1'b0);
    #12;
    chk("rst_load",      32'(load),         32'h0);
    chk("rst_bubble",    32'(bubble),       32'h0);
    chk("rst_flush_out", 32'(flush_out),    32'h0);
    chk("rst_stall",     32'(stall_cycles), 32'h0);
    chk("rst_timeout",   32'(timeout),      32'h0);
    next_cycle();
    rst = 1'b0;
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("idle_load", 32'(load), 32'hF);
    next_cycle();

    // ---- two ports, resp0 at cycle 3, resp1 at cycle 7 ----
    for (int c = 0; c < 8; c++) begin
      drive(2'b11, (c == 3) ? 2'b01 : ((c == 7) ? 2'b10 : 2'b00), 1'b0, 1'b0);
      @(negedge clk);
      chk("dual_load", 32'(load), (c < 7) ? 32'h0 : 32'hF);
      next_cycle();
    end
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("dual_stall", 32'(stall_cycles), 32'd7);
    chk("dual_state", 32'(dut.state_q),  32'(RUN));
    chk("dual_done",  32'(dut.done_q),   32'h0);
    next_cycle();

    // ---- hit in one cycle: no stall ----
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    chk("hit_load", 32'(load), 32'hF);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("hit_stall", 32'(stall_cycles), 32'd7);
    chk("hit_state", 32'(dut.state_q),  32'(RUN));
    next_cycle();

    // ---- load-use hazard ----
    drive(2'b00, 2'b00, 1'b1, 1'b0);
    @(negedge clk);
    chk("haz_load",      32'(load),      32'hE);
    chk("haz_bubble",    32'(bubble),    32'h2);
    chk("haz_flush_out", 32'(flush_out), 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_haz_load",   32'(load),   32'hF);
    chk("post_haz_bubble", 32'(bubble), 32'h0);
    next_cycle();

    // ---- flush at cycle 2 (and again at 4) during a hold released at cycle 5 ----
    for (int c = 0; c < 6; c++) begin
      drive(2'b01, (c == 5) ? 2'b01 : 2'b00, 1'b0, (c == 2) || (c == 4));
      @(negedge clk);
      chk("hflush_load",      32'(load),      (c < 5) ? 32'h0 : 32'hF);
      chk("hflush_flush_out", 32'(flush_out), (c < 5) ? 32'h0 : 32'h3);
      next_cycle();
    end
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("hflush_after_fo",   32'(flush_out),    32'h0);
    chk("hflush_after_load", 32'(load),         32'hF);
    chk("hflush_stall",      32'(stall_cycles), 32'd12);
    next_cycle();

    // ---- flush and hazard together ----
    drive(2'b00, 2'b00, 1'b1, 1'b1);
    @(negedge clk);
    chk("fh_flush_out", 32'(flush_out), 32'h3);
    chk("fh_load",      32'(load),      32'hF);
    chk("fh_bubble",    32'(bubble),    32'h0);
    next_cycle();

    // ---- request withdrawn while waiting ----
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("wd_hold_load", 32'(load), 32'h0);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("withdraw_load",  32'(load),         32'hF);
    chk("withdraw_stall", 32'(stall_cycles), 32'd13);
    next_cycle();

    // ---- watchdog and counter saturation: 300 held cycles, resp at 300 ----
    for (int j = 0; j <= 300; j++) begin
      drive(2'b10, (j == 300) ? 2'b10 : 2'b00, 1'b0, 1'b0);
      @(negedge clk);
      if (j == TO - 1) chk("tmo_before", 32'(timeout),      32'h0);
      if (j == TO)     chk("tmo_set",    32'(timeout),      32'h1);
      if (j == 241)    chk("stall_254",  32'(stall_cycles), 32'd254);
      if (j == 260)    chk("stall_sat",  32'(stall_cycles), 32'd255);
      if (j == 300)    chk("tmo_release_load", 32'(load),   32'hF);
      next_cycle();
    end
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("tmo_sticky", 32'(timeout),      32'h1);
    chk("stall_hold", 32'(stall_cycles), 32'd255);
    next_cycle();

    // ---- asynchronous reset in the middle of MEM_WAIT ----
    drive(2'b11, 2'b00, 1'b0, 1'b0);
    next_cycle();
    drive(2'b11, 2'b01, 1'b0, 1'b0);
    next_cycle();
    drive(2'b11, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_done", 32'(dut.done_q), 32'h1);
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("arst_load",    32'(load),          32'h0);
    chk("arst_fo",      32'(flush_out),     32'h0);
    chk("arst_bubble",  32'(bubble),        32'h0);
    chk("arst_stall",   32'(stall_cycles),  32'h0);
    chk("arst_timeout", 32'(timeout),       32'h0);
    chk("arst_done",    32'(dut.done_q),    32'h0);
    chk("arst_state",   32'(dut.state_q),   32'(RUN));
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(load), 32'hF);
    next_cycle();
    // Port 0 responded before reset; it must need service again now.
    drive(2'b01, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_hold", 32'(load), 32'h0);
    next_cycle();
    drive(2'b01, 2'b01, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_release", 32'(load), 32'hF);
    next_cycle();
    drive(2'b00, 2'b00, 1'b0, 1'b0);
    @(negedge clk);
    chk("post_rst_stall", 32'(stall_cycles), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
